// File: rtl/x_top_uart_echo_host_pkg.sv
// Shared types and constants for the UART echo host.
// X_TOP_UART_ECHO_HOST_LFSR_EN switches the byte pattern from increment to LFSR.
package x_top_uart_echo_host_pkg;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

  // x^8+x^6+x^5+x^4+1 as a shift-left Fibonacci tap mask
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_CHECK,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    R_HUNT,
    R_START,
    R_DATA,
    R_STOP
  } rx_state_e;

  function automatic logic [FRAME_BITS-1:0] frame_of(input logic [DATA_BITS-1:0] b);
    return {1'b1, b, 1'b0};
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [7:0] next_byte(input logic [7:0] b);
`ifdef X_TOP_UART_ECHO_HOST_LFSR_EN
    return {b[6:0], ^(b & LFSR_TAPS)};
`else
    return b + 8'd1;
`endif
  endfunction

endpackage

// File: rtl/x_top_uart_echo_host_rx.sv
// UART receiver for the echo host: 2-flop synchronizer, start confirm at mid-bit,
// data/stop sampling at full-bit intervals. Hunts only while i_en is high.
module x_top_uart_echo_host_rx
  import x_top_uart_echo_host_pkg::*;
#(
  parameter int p_div = 16
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_en,
  input  logic       i_rx,
  output logic       o_start,
  output logic       o_valid,
  output logic [7:0] o_byte,
  output logic       o_stop_ok
);

  localparam int CW = $clog2(p_div + 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(p_div - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(p_div / 2 - 1);

  rx_state_e       st_q;
  logic            sync1_q, sync2_q, prev_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      sh_q, byte_q;
  logic            stop_q, valid_q, start_q;

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      st_q    <= R_HUNT;
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      byte_q  <= '0;
      stop_q  <= 1'b0;
      valid_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      valid_q <= 1'b0;
      start_q <= 1'b0;
      if (!i_en) begin
        st_q  <= R_HUNT;
        cnt_q <= '0;
      end else begin
        case (st_q)
          R_HUNT: begin
            if (prev_q && !sync2_q) begin
              cnt_q <= '0;
              st_q  <= R_START;
            end
          end
          R_START: begin
            // a low shorter than half a bit is a glitch, not a start
            if (cnt_q == HALF_M1) begin
              cnt_q <= '0;
              if (!sync2_q) begin
                bit_q   <= '0;
                start_q <= 1'b1;
                st_q    <= R_DATA;
              end else begin
                st_q <= R_HUNT;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          R_DATA: begin
            if (cnt_q == FULL_M1) begin
              cnt_q <= '0;
              sh_q  <= {sync2_q, sh_q[7:1]};
              bit_q <= bit_q + 1'b1;
              if (bit_q == 3'd7) st_q <= R_STOP;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          R_STOP: begin
            if (cnt_q == FULL_M1) begin
              cnt_q   <= '0;
              byte_q  <= sh_q;
              stop_q  <= sync2_q;
              valid_q <= 1'b1;
              st_q    <= R_HUNT;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: st_q <= R_HUNT;
        endcase
      end
    end
  end

  assign o_start   = start_q;
  assign o_valid   = valid_q;
  assign o_byte    = byte_q;
  assign o_stop_ok = stop_q;

endmodule

// File: rtl/x_top_uart_echo_host.sv
// UART echo host: sends a byte run, waits for each echo, counts mismatches/timeouts.
// Define X_TOP_UART_ECHO_HOST_LFSR_EN for an LFSR byte pattern instead of increment.
module x_top_uart_echo_host
  import x_top_uart_echo_host_pkg::*;
#(
  parameter int p_clk_hz       = 1000000,
  parameter int p_baud         = 9600,
  parameter int p_timeout_bits = 20
) (
  input  logic       i_clk,
  input  logic       i_nrst,
  input  logic       i_start,
  input  logic [7:0] i_seed,
  input  logic [7:0] i_count,
  output logic       o_tx,
  input  logic       i_rx,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [7:0] o_err_cnt,
  output logic       o_timeout
);

  localparam int DIV = p_clk_hz / p_baud;
  localparam int CW  = $clog2(DIV + 1);
  localparam int TO  = p_timeout_bits * DIV;
  localparam int TW  = $clog2(TO + 1);
  localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);
  localparam logic [TW-1:0] TO_M1  = TW'(TO - 1);

  state_e                state_q;
  logic [7:0]            cur_q, rem_q, err_q;
  logic [FRAME_BITS-1:0] tx_shift_q;
  logic [3:0]            bit_q;
  logic [CW-1:0]         baud_q;
  logic [TW-1:0]         wait_q;
  logic                  started_q, skip_q;
  logic                  tx_q, done_q, pass_q, tout_q;

  logic [7:0] seed_d, nxt_d;
  logic       rx_en, rx_start, rx_valid, rx_stop_ok;
  logic [7:0] rx_byte;

`ifdef X_TOP_UART_ECHO_HOST_LFSR_EN
  assign seed_d = (i_seed == 8'h00) ? 8'h01 : i_seed;
`else
  assign seed_d = i_seed;
`endif
  assign nxt_d = next_byte(cur_q);
  assign rx_en = (state_q == S_WAIT);

  x_top_uart_echo_host_rx #(.p_div(DIV)) u_rx (
    .i_clk     (i_clk),
    .i_nrst    (i_nrst),
    .i_en      (rx_en),
    .i_rx      (i_rx),
    .o_start   (rx_start),
    .o_valid   (rx_valid),
    .o_byte    (rx_byte),
    .o_stop_ok (rx_stop_ok)
  );

  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      state_q    <= S_IDLE;
      cur_q      <= '0;
      rem_q      <= '0;
      err_q      <= '0;
      tx_shift_q <= '1;
      bit_q      <= '0;
      baud_q     <= '0;
      wait_q     <= '0;
      started_q  <= 1'b0;
      skip_q     <= 1'b0;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      tout_q     <= 1'b0;
    end else begin
      tx_q   <= 1'b1;
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            cur_q      <= seed_d;
            rem_q      <= i_count;
            err_q      <= '0;
            pass_q     <= 1'b0;
            tout_q     <= 1'b0;
            tx_shift_q <= frame_of(seed_d);
            bit_q      <= '0;
            baud_q     <= '0;
            state_q    <= (i_count == 8'd0) ? S_DONE : S_SEND;
          end
        end
        S_SEND: begin
          // line lags the shift register by one cycle, so the frame starts after entry
          tx_q <= tx_shift_q[0];
          if (baud_q == DIV_M1) begin
            baud_q     <= '0;
            tx_shift_q <= {1'b1, tx_shift_q[FRAME_BITS-1:1]};
            if (bit_q == 4'(FRAME_BITS - 1)) begin
              bit_q     <= '0;
              wait_q    <= '0;
              started_q <= 1'b0;
              state_q   <= S_WAIT;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end else begin
            baud_q <= baud_q + 1'b1;
          end
        end
        S_WAIT: begin
          if (rx_start) started_q <= 1'b1;
          if (rx_valid) begin
            skip_q  <= 1'b0;
            state_q <= S_CHECK;
          end else if (!started_q && !rx_start && wait_q == TO_M1) begin
            err_q   <= sat_inc(err_q);
            tout_q  <= 1'b1;
            skip_q  <= 1'b1;
            state_q <= S_CHECK;
          end else if (!started_q) begin
            wait_q <= wait_q + 1'b1;
          end
        end
        S_CHECK: begin
          if (!skip_q && (rx_byte != cur_q || !rx_stop_ok)) err_q <= sat_inc(err_q);
          rem_q <= rem_q - 8'd1;
          if (rem_q != 8'd1) begin
            cur_q      <= nxt_d;
            tx_shift_q <= frame_of(nxt_d);
            bit_q      <= '0;
            baud_q     <= '0;
            state_q    <= S_SEND;
          end else begin
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          pass_q  <= (err_q == 8'd0);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_tx      = tx_q;
  assign o_busy    = (state_q != S_IDLE);
  assign o_done    = done_q;
  assign o_pass    = pass_q;
  assign o_err_cnt = err_q;
  assign o_timeout = tout_q;

endmodule

// File: tb/tb_x_top_uart_echo_host.sv
// Bench for x_top_uart_echo_host: behavioural echo device plus run-level model.
module tb_x_top_uart_echo_host;

  localparam int CLK_HZ = 160000;
  localparam int BAUD   = 10000;
  localparam int TOB    = 20;
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int TO     = TOB * DIV;

  localparam int M_ECHO    = 0;
  localparam int M_INV     = 1;
  localparam int M_SILENT  = 2;
  localparam int M_BADSTOP = 3;
  localparam int M_GLITCH  = 4;

  logic       i_clk = 1'b0;
  logic       i_nrst = 1'b0;
  logic       i_start = 1'b0;
  logic [7:0] i_seed = 8'h00;
  logic [7:0] i_count = 8'h00;
  logic       i_rx = 1'b1;
  logic       o_tx, o_busy, o_done, o_pass, o_timeout;
  logic [7:0] o_err_cnt;

  x_top_uart_echo_host #(
    .p_clk_hz(CLK_HZ), .p_baud(BAUD), .p_timeout_bits(TOB)
  ) dut (
    .i_clk(i_clk), .i_nrst(i_nrst), .i_start(i_start), .i_seed(i_seed),
    .i_count(i_count), .o_tx(o_tx), .i_rx(i_rx), .o_busy(o_busy),
    .o_done(o_done), .o_pass(o_pass), .o_err_cnt(o_err_cnt), .o_timeout(o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int echo_mode = M_ECHO;
  logic [7:0] exp_q[$];
  logic [7:0] cap[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] model_next(input logic [7:0] b);
`ifdef X_TOP_UART_ECHO_HOST_LFSR_EN
    int fb;
    fb = (b[7] + b[5] + b[4] + b[3]) % 2;
    return 8'(((int'(b) * 2) % 256) + fb);
`else
    return 8'((int'(b) + 1) % 256);
`endif
  endfunction

  task automatic wait_n(input int n, inout bit rs);
    repeat (n) begin
      @(negedge i_clk);
      if (!i_nrst) rs = 1'b1;
    end
  endtask

  // echo device: retransmits what it heard, per echo_mode
  task automatic respond(input logic [7:0] b, input int t_end);
    logic [9:0] fr;
    logic [7:0] e0;
    int d;
    if (echo_mode == M_SILENT) begin
      e0 = o_err_cnt;
      d = 0;
      while (o_err_cnt == e0 && d < 2 * TO) begin
        @(negedge i_clk);
        d++;
      end
      chk("timeout_delay", cyc - t_end, TO);
      chk("timeout_flag", o_timeout, 1);
      chk("timeout_err_step", o_err_cnt, e0 + 8'd1);
    end else begin
      repeat (2 * DIV) @(negedge i_clk);
      if (echo_mode == M_GLITCH) begin
        i_rx = 1'b0;
        repeat (DIV / 4) @(negedge i_clk);
        i_rx = 1'b1;
        repeat (DIV) @(negedge i_clk);
      end
      fr = {(echo_mode == M_BADSTOP) ? 1'b0 : 1'b1,
            b ^ ((echo_mode == M_INV) ? 8'h01 : 8'h00), 1'b0};
      for (int i = 0; i < 10; i++) begin
        i_rx = fr[i];
        repeat (DIV) @(negedge i_clk);
      end
      i_rx = 1'b1;
    end
  endtask

  // line monitor: decodes every frame on o_tx and checks it against the model queue
  initial begin : mon
    logic prev, st0, stp;
    logic [7:0] b;
    int t_end;
    bit rs;
    prev = 1'b1;
    forever begin
      @(negedge i_clk);
      if (i_nrst && prev && !o_tx) begin
        rs = 1'b0;
        wait_n(DIV / 2, rs);
        st0 = o_tx;
        for (int i = 0; i < 8; i++) begin
          wait_n(DIV, rs);
          b[i] = o_tx;
        end
        wait_n(DIV, rs);
        stp = o_tx;
        wait_n(DIV / 2 - 1, rs);
        t_end = cyc;
        if (!rs) begin
          chk("tx_start_bit", st0, 0);
          chk("tx_stop_bit", stp, 1);
          n_vec++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL tx_unexpected_frame: got byte %0h, expected no frame", b);
          end else if (b !== exp_q[0]) begin
            n_bad++;
            $display("FAIL tx_byte: got %0h, expected %0h", b, exp_q[0]);
          end
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          cap.push_back(b);
          fork
            respond(b, t_end);
          join_none
        end
      end
      prev = o_tx;
    end
  end

  always @(negedge i_clk) begin
    if (i_nrst && !o_busy) chk("idle_tx_high", o_tx, 1);
    if (i_nrst && o_done) chk("done_not_busy", o_busy, 0);
  end

  task automatic run(input logic [7:0] seed, input logic [7:0] cnt, input int mode,
                     input string tag);
    int exp_err, lat, bound;
    bit exp_to, got;
    logic [7:0] b;
    echo_mode = mode;
    exp_q.delete();
    cap.delete();
    b = seed;
`ifdef X_TOP_UART_ECHO_HOST_LFSR_EN
    if (b == 8'h00) b = 8'h01;
`endif
    for (int k = 0; k < int'(cnt); k++) begin
      exp_q.push_back(b);
      b = model_next(b);
    end
    exp_err = (mode == M_ECHO || mode == M_GLITCH) ? 0 : int'(cnt);
    exp_to  = (mode == M_SILENT && cnt != 8'd0);
    bound   = int'(cnt) * (18 * DIV + TO) + 20;
    @(negedge i_clk);
    i_seed = seed; i_count = cnt; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk({tag, "_busy_after_start"}, o_busy, 1);
    chk({tag, "_err_cleared"}, o_err_cnt, 0);
    chk({tag, "_pass_cleared"}, o_pass, 0);
    lat = 1; got = 1'b0;
    while (!got && lat < bound) begin
      if (o_done) got = 1'b1;
      else begin
        @(negedge i_clk);
        lat++;
      end
    end
    chk({tag, "_done_seen"}, got, 1);
    if (cnt == 8'd0) chk({tag, "_done_latency"}, lat, 2);
    chk({tag, "_err_cnt"}, o_err_cnt, exp_err);
    chk({tag, "_pass"}, o_pass, exp_err == 0);
    chk({tag, "_timeout"}, o_timeout, exp_to);
    chk({tag, "_frames_left"}, exp_q.size(), 0);
    chk({tag, "_frames_sent"}, cap.size(), cnt);
    @(negedge i_clk);
    chk({tag, "_done_width"}, o_done, 0);
    chk({tag, "_idle_busy"}, o_busy, 0);
    chk({tag, "_pass_held"}, o_pass, exp_err == 0);
    repeat (4 * DIV) @(negedge i_clk);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : stim
    int w;
    repeat (3) @(negedge i_clk);
    chk("rst_tx", o_tx, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_pass", o_pass, 0);
    chk("rst_err", o_err_cnt, 0);
    chk("rst_timeout", o_timeout, 0);
    i_nrst = 1'b1;
    repeat (2) @(negedge i_clk);

    run(8'h10, 8'd4, M_ECHO, "loop");
`ifndef X_TOP_UART_ECHO_HOST_LFSR_EN
    chk("pin_loop_b0", cap[0], 8'h10);
    chk("pin_loop_b3", cap[3], 8'h13);
`endif
    run(8'h20, 8'd5, M_INV, "inv");
    run(8'h30, 8'd3, M_SILENT, "silent");
    run(8'h44, 8'd0, M_ECHO, "zero");
    run(8'hFE, 8'd3, M_ECHO, "wrap");
`ifndef X_TOP_UART_ECHO_HOST_LFSR_EN
    chk("pin_wrap_b1", cap[1], 8'hFF);
    chk("pin_wrap_b2", cap[2], 8'h00);
`endif
    run(8'h60, 8'd2, M_BADSTOP, "badstop");
    run(8'h70, 8'd2, M_GLITCH, "glitch");

    // a start request while busy must not disturb the run in progress
    fork
      run(8'h40, 8'd2, M_ECHO, "busystart");
      begin
        repeat (50) @(negedge i_clk);
        i_seed = 8'h99; i_count = 8'd7; i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
      end
    join

    // reset in the middle of a frame
    echo_mode = M_ECHO;
    exp_q.delete();
    @(negedge i_clk);
    i_seed = 8'h55; i_count = 8'd3; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    w = 0;
    while (o_tx && w < 20) begin
      @(negedge i_clk);
      w++;
    end
    chk("rst_mid_frame_started", o_tx, 0);
    repeat (3 * DIV) @(negedge i_clk);
    chk("rst_mid_busy_before", o_busy, 1);
    i_nrst = 1'b0;
    @(negedge i_clk);
    chk("rst_mid_tx", o_tx, 1);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_done", o_done, 0);
    chk("rst_mid_err", o_err_cnt, 0);
    chk("rst_mid_timeout", o_timeout, 0);
    chk("rst_mid_pass", o_pass, 0);
    i_nrst = 1'b1;
    repeat (30 * DIV) @(negedge i_clk);
    chk("rst_mid_stays_idle", o_busy, 0);

    run(8'h80, 8'd1, M_ECHO, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
